// File: rtl/vga_timing_core_if.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_core_if
//  Brief    : Control/status bundle between the raster timing core and the
//             pixel-fetch side: enable in, counters, sync, blank and strobes out.
//  Revision : 1.0  initial release
// ============================================================================
interface vga_timing_core_if #(
  parameter int CW  = 11,
  parameter int FCW = 16
);
  logic           Enable;
  logic [CW-1:0]  Counter_X;
  logic [CW-1:0]  Counter_Y;
  logic           VGA_HS;
  logic           VGA_VS;
  logic           VGA_Blank_N;
  logic           VGA_Sync_N;
  logic           Line_Start;
  logic           Frame_Start;
  logic [FCW-1:0] Frame_Count;

  // Timing core side: consumes Enable, produces all raster outputs
  modport master (
    input  Enable,
    output Counter_X, Counter_Y, VGA_HS, VGA_VS, VGA_Blank_N, VGA_Sync_N,
           Line_Start, Frame_Start, Frame_Count
  );

  // Consumer side: drives Enable, observes raster outputs
  modport slave (
    output Enable,
    input  Counter_X, Counter_Y, VGA_HS, VGA_VS, VGA_Blank_N, VGA_Sync_N,
           Line_Start, Frame_Start, Frame_Count
  );
endinterface
`default_nettype wire

// File: rtl/vga_timing_core.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_core
//  Brief    : Parametrised raster timing generator. Free-running X/Y counters
//             with frame counter; sync, blank and line/frame strobes are
//             decoded from the counters and delayed by PIPE_DELAY stages.
//  Revision : 1.0  initial release
// ============================================================================
module vga_timing_core #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int H_SYNC_POL = 0,
  parameter int V_SYNC_POL = 0,
  parameter int PIPE_DELAY = 2,
  parameter int CW         = 11,
  parameter int FCW        = 16
) (
  input  wire logic         VGA_Clk,
  input  wire logic         Reset,
  vga_timing_core_if.master bus
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CW-1:0] c_H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] c_V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] c_H_VIS    = CW'(H_VISIBLE);
  localparam logic [CW-1:0] c_V_VIS    = CW'(V_VISIBLE);
  localparam logic [CW-1:0] c_HS_START = CW'(H_VISIBLE + H_FRONT);
  localparam logic [CW-1:0] c_HS_END   = CW'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [CW-1:0] c_VS_START = CW'(V_VISIBLE + V_FRONT);
  localparam logic [CW-1:0] c_VS_END   = CW'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  // Inactive sync levels: the pin sits at the opposite of its active polarity
  localparam logic c_HS_IDLE = (H_SYNC_POL == 0);
  localparam logic c_VS_IDLE = (V_SYNC_POL == 0);

  // Bit positions inside one pipeline stage
  localparam int c_B_HS  = 0;
  localparam int c_B_VS  = 1;
  localparam int c_B_VIS = 2;
  localparam int c_B_LS  = 3;
  localparam int c_B_FS  = 4;
  localparam logic [4:0] c_STAGE_RST = {1'b0, 1'b0, 1'b0, c_VS_IDLE, c_HS_IDLE};

  logic [CW-1:0]  cnt_x_q, cnt_x_d;
  logic [CW-1:0]  cnt_y_q, cnt_y_d;
  logic [FCW-1:0] frame_cnt_q, frame_cnt_d;
  logic [4:0]     pipe_q [PIPE_DELAY];
  logic [4:0]     pipe_d [PIPE_DELAY];
  logic [4:0]     w_raw;

  // Raster advance: X wraps at line end, Y and frame count step on X wrap
  always_comb begin
    cnt_x_d     = cnt_x_q;
    cnt_y_d     = cnt_y_q;
    frame_cnt_d = frame_cnt_q;
    if (bus.Enable) begin
      if (cnt_x_q == c_H_LAST) begin
        cnt_x_d = '0;
        if (cnt_y_q == c_V_LAST) begin
          cnt_y_d     = '0;
          frame_cnt_d = frame_cnt_q + 1'b1;
        end else begin
          cnt_y_d = cnt_y_q + 1'b1;
        end
      end else begin
        cnt_x_d = cnt_x_q + 1'b1;
      end
    end
  end

  // Decode undelayed timing terms; strobes only fire on an advancing cycle
  always_comb begin
    w_raw          = '0;
    w_raw[c_B_HS]  = ((cnt_x_q >= c_HS_START) && (cnt_x_q <= c_HS_END)) ^ c_HS_IDLE;
    w_raw[c_B_VS]  = ((cnt_y_q >= c_VS_START) && (cnt_y_q <= c_VS_END)) ^ c_VS_IDLE;
    w_raw[c_B_VIS] = (cnt_x_q < c_H_VIS) && (cnt_y_q < c_V_VIS);
    w_raw[c_B_LS]  = (cnt_x_q == '0) && bus.Enable;
    w_raw[c_B_FS]  = (cnt_x_q == '0) && (cnt_y_q == '0) && bus.Enable;
  end

  // Output delay line; keeps shifting even while the counters are held
  always_comb begin
    pipe_d[0] = w_raw;
    for (int i = 1; i < PIPE_DELAY; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  // Counter and frame-count registers
  always_ff @(posedge VGA_Clk or posedge Reset) begin
    if (Reset) begin
      cnt_x_q     <= '0;
      cnt_y_q     <= '0;
      frame_cnt_q <= '0;
    end else begin
      cnt_x_q     <= cnt_x_d;
      cnt_y_q     <= cnt_y_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Pipeline registers, cleared to inactive output levels
  always_ff @(posedge VGA_Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < PIPE_DELAY; i++) begin
        pipe_q[i] <= c_STAGE_RST;
      end
    end else begin
      for (int i = 0; i < PIPE_DELAY; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

  assign bus.Counter_X   = cnt_x_q;
  assign bus.Counter_Y   = cnt_y_q;
  assign bus.Frame_Count = frame_cnt_q;
  assign bus.VGA_HS      = pipe_q[PIPE_DELAY-1][c_B_HS];
  assign bus.VGA_VS      = pipe_q[PIPE_DELAY-1][c_B_VS];
  assign bus.VGA_Blank_N = pipe_q[PIPE_DELAY-1][c_B_VIS];
  assign bus.Line_Start  = pipe_q[PIPE_DELAY-1][c_B_LS];
  assign bus.Frame_Start = pipe_q[PIPE_DELAY-1][c_B_FS];
  assign bus.VGA_Sync_N  = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_core.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_timing_core
//  Brief    : Directed self-checking bench for vga_timing_core. Three
//             instances: default 640x480 mode (a), active-high sync with a
//             shortened frame (b), and the tiny 8x6 mode with PIPE_DELAY=1 (c).
//  Revision : 1.0  initial release
// ============================================================================
module tb_vga_timing_core;

  logic clk = 1'b0;
  logic rst_a, rst_b, rst_c;
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   fs_seen;
  int   u, x, y;

  always #5 clk = ~clk;

  vga_timing_core_if #(.CW(11), .FCW(16)) if_a ();
  vga_timing_core_if #(.CW(11), .FCW(16)) if_b ();
  vga_timing_core_if #(.CW(11), .FCW(2))  if_c ();

  vga_timing_core dut_a (.VGA_Clk(clk), .Reset(rst_a), .bus(if_a));

  vga_timing_core #(
    .H_SYNC_POL(1), .V_SYNC_POL(1),
    .V_VISIBLE(10), .V_FRONT(2), .V_SYNC(2), .V_BACK(2)
  ) dut_b (.VGA_Clk(clk), .Reset(rst_b), .bus(if_b));

  vga_timing_core #(
    .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .PIPE_DELAY(1), .FCW(2)
  ) dut_c (.VGA_Clk(clk), .Reset(rst_c), .bus(if_c));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic in_rng(input int v, input int lo, input int hi);
    return (v >= lo) && (v <= hi);
  endfunction

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    if_a.Enable = 1'b1; if_b.Enable = 1'b1; if_c.Enable = 1'b1;
    repeat (3) tick();

    // ---- reset state ----
    check("a_rst_x",    32'(if_a.Counter_X),   0);
    check("a_rst_y",    32'(if_a.Counter_Y),   0);
    check("a_rst_fc",   32'(if_a.Frame_Count), 0);
    check("a_rst_hs",   32'(if_a.VGA_HS),      1);
    check("a_rst_vs",   32'(if_a.VGA_VS),      1);
    check("a_rst_blk",  32'(if_a.VGA_Blank_N), 0);
    check("a_rst_ls",   32'(if_a.Line_Start),  0);
    check("a_rst_fs",   32'(if_a.Frame_Start), 0);
    check("a_sync_n",   32'(if_a.VGA_Sync_N),  1);
    check("b_rst_hs",   32'(if_b.VGA_HS),      0);
    check("b_rst_vs",   32'(if_b.VGA_VS),      0);
    check("c_rst_hs",   32'(if_c.VGA_HS),      1);
    check("c_rst_vs",   32'(if_c.VGA_VS),      1);

    // ---- default mode: first lines, outputs lag counters by 2 ----
    rst_a = 1'b0;
    for (int t = 1; t <= 1700; t++) begin
      tick();
      u = t - 2;
      check("a_x", 32'(if_a.Counter_X), 32'(t % 800));
      if (u < 0) begin
        check("a_hs0",  32'(if_a.VGA_HS),      1);
        check("a_blk0", 32'(if_a.VGA_Blank_N), 0);
        check("a_fs0",  32'(if_a.Frame_Start), 0);
      end else begin
        x = u % 800;
        y = u / 800;
        check("a_hs",  32'(if_a.VGA_HS),      32'(!in_rng(x, 656, 751)));
        check("a_vs",  32'(if_a.VGA_VS),      1);
        check("a_blk", 32'(if_a.VGA_Blank_N), 32'((x < 640) && (y < 480)));
        check("a_ls",  32'(if_a.Line_Start),  32'(x == 0));
        check("a_fs",  32'(if_a.Frame_Start), 32'((x == 0) && (y == 0)));
      end
    end
    check("a_y_1700", 32'(if_a.Counter_Y), 2);

    // ---- async reset between edges at X=500, Y=2 ----
    repeat (400) tick();
    check("a_x_500",   32'(if_a.Counter_X),   500);
    check("a_y_2",     32'(if_a.Counter_Y),   2);
    check("a_blk_pre", 32'(if_a.VGA_Blank_N), 1);
    #2 rst_a = 1'b1;
    #1;
    check("a_ar_x",   32'(if_a.Counter_X),   0);
    check("a_ar_y",   32'(if_a.Counter_Y),   0);
    check("a_ar_fc",  32'(if_a.Frame_Count), 0);
    check("a_ar_hs",  32'(if_a.VGA_HS),      1);
    check("a_ar_vs",  32'(if_a.VGA_VS),      1);
    check("a_ar_blk", 32'(if_a.VGA_Blank_N), 0);
    check("a_ar_ls",  32'(if_a.Line_Start),  0);
    check("a_ar_fs",  32'(if_a.Frame_Start), 0);
    tick();
    rst_a = 1'b0;
    tick();
    check("a_rel_x1",  32'(if_a.Counter_X),   1);
    check("a_rel_fs1", 32'(if_a.Frame_Start), 0);
    tick();
    check("a_rel_fs2", 32'(if_a.Frame_Start), 1);
    tick();
    check("a_rel_fs3", 32'(if_a.Frame_Start), 0);

    // ---- hold at X=300, Y=10 (8300 enabled edges from release) ----
    repeat (8297) tick();
    check("a_x_300", 32'(if_a.Counter_X), 300);
    check("a_y_10",  32'(if_a.Counter_Y), 10);
    if_a.Enable = 1'b0;
    for (int t = 0; t < 100; t++) begin
      tick();
      check("a_hold_x",  32'(if_a.Counter_X),   300);
      check("a_hold_y",  32'(if_a.Counter_Y),   10);
      check("a_hold_fc", 32'(if_a.Frame_Count), 0);
    end
    check("a_hold_blk", 32'(if_a.VGA_Blank_N), 1);
    check("a_hold_hs",  32'(if_a.VGA_HS),      1);
    check("a_hold_ls",  32'(if_a.Line_Start),  0);
    if_a.Enable = 1'b1;
    tick();
    check("a_resume_x", 32'(if_a.Counter_X), 301);
    check("a_resume_y", 32'(if_a.Counter_Y), 10);

    // ---- hold at (0,0): exactly one Frame_Start once released ----
    if_a.Enable = 1'b0;
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    fs_seen = 0;
    for (int t = 0; t < 100; t++) begin
      tick();
      fs_seen += int'(if_a.Frame_Start);
    end
    check("a_hold00_x",  32'(if_a.Counter_X), 0);
    check("a_hold00_fs", 32'(fs_seen),        0);
    if_a.Enable = 1'b1;
    fs_seen = 0;
    for (int t = 0; t < 10; t++) begin
      tick();
      fs_seen += int'(if_a.Frame_Start);
    end
    check("a_one_fs", 32'(fs_seen), 1);

    // ---- active-high sync, 800 x 16 raster ----
    rst_b = 1'b0;
    for (int t = 1; t <= 12900; t++) begin
      tick();
      u = t - 2;
      if (u < 0) begin
        check("b_hs0", 32'(if_b.VGA_HS), 0);
        check("b_vs0", 32'(if_b.VGA_VS), 0);
      end else begin
        check("b_hs", 32'(if_b.VGA_HS), 32'(in_rng(u % 800, 656, 751)));
        check("b_vs", 32'(if_b.VGA_VS), 32'(in_rng((u / 800) % 16, 12, 13)));
      end
    end
    check("b_wrap_x",  32'(if_b.Counter_X),   100);
    check("b_wrap_y",  32'(if_b.Counter_Y),   0);
    check("b_wrap_fc", 32'(if_b.Frame_Count), 1);

    // ---- tiny 8x6 mode, PIPE_DELAY=1, 2-bit frame count ----
    rst_c = 1'b0;
    for (int t = 1; t <= 192; t++) begin
      tick();
      u = t - 1;
      x = u % 8;
      y = (u / 8) % 6;
      check("c_x",   32'(if_c.Counter_X),   32'(t % 8));
      check("c_y",   32'(if_c.Counter_Y),   32'((t / 8) % 6));
      check("c_hs",  32'(if_c.VGA_HS),      32'(!in_rng(x, 5, 6)));
      check("c_vs",  32'(if_c.VGA_VS),      32'(y != 4));
      check("c_blk", 32'(if_c.VGA_Blank_N), 32'((x < 4) && (y < 3)));
      check("c_ls",  32'(if_c.Line_Start),  32'(x == 0));
      check("c_fs",  32'(if_c.Frame_Start), 32'((x == 0) && (y == 0)));
      check("c_fc",  32'(if_c.Frame_Count), 32'((t / 48) % 4));
    end
    check("c_fc_final", 32'(if_c.Frame_Count), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
